// File: rtl/ariane_pkg.sv
// Shared core types: the LSU control bundle carried between issue and the
// load/store units, plus core-wide sizing constants.
package ariane_pkg;

  localparam int unsigned XLEN                 = 64;
  localparam int unsigned VLEN                 = 64;
  localparam int unsigned TRANS_ID_BITS        = 3;
  localparam int unsigned ST_ISSUE_QUEUE_DEPTH = 2;

  typedef enum logic [7:0] {
    ADD, SD, SW, SH, SB, AMO_ADDW, AMO_SWAPD
  } fu_op;

  typedef struct packed {
    logic [VLEN-1:0]          vaddr;
    logic [XLEN-1:0]          data;
    logic [(XLEN/8)-1:0]      be;
    fu_op                     operation;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } lsu_ctrl_t;

endpackage

// File: rtl/st_issue_queue_pkg.sv
// Local helpers for the store issue queue.
package st_issue_queue_pkg;

  // Loads and stores alias when they touch the same doubleword of the page.
  localparam int unsigned OFFSET_LSB = 3;
  localparam int unsigned OFFSET_MSB = 11;

  function automatic logic offset_hit(
    input logic [OFFSET_MSB:OFFSET_LSB] a,
    input logic [OFFSET_MSB:OFFSET_LSB] b
  );
    return a == b;
  endfunction

endpackage

// File: rtl/st_issue_queue_if.sv
// Issue-side push and store-unit-side pop handshakes of the store issue queue.
interface st_issue_queue_if;
  import ariane_pkg::*;

  logic      valid_i;
  lsu_ctrl_t lsu_ctrl_i;
  logic      ready_o;
  logic      valid_o;
  lsu_ctrl_t lsu_ctrl_o;
  logic      pop_i;

  modport slave (
    input  valid_i, lsu_ctrl_i, pop_i,
    output ready_o, valid_o, lsu_ctrl_o
  );

  modport master (
    output valid_i, lsu_ctrl_i, pop_i,
    input  ready_o, valid_o, lsu_ctrl_o
  );
endinterface

// File: rtl/st_issue_queue.sv
// Small fall-through FIFO in front of the store unit; also flags queued stores
// whose page offset aliases a load so the load path can wait.
module st_issue_queue
  import ariane_pkg::*;
  import st_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = ST_ISSUE_QUEUE_DEPTH,
  parameter bit          FALL_THROUGH = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  st_issue_queue_if.slave        sq,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] usage_o,
  input  logic [11:0]            page_offset_i,
  output logic                   page_offset_matches_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  lsu_ctrl_t        mem_q [DEPTH];
  lsu_ctrl_t        mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  ptr_t             wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t             usage_q, usage_d;
  logic             ready_q, ready_d;

  logic             empty, ft_active, valid_out, push, pop, bypass;
  logic [DEPTH-1:0] entry_hit;
  logic             unused_offset_bits;

  assign empty     = (usage_q == '0);
  assign ft_active = FALL_THROUGH && empty && sq.valid_i && !flush_i;
  assign valid_out = !flush_i && (!empty || ft_active);
  assign push      = sq.valid_i && ready_q && !flush_i;
  assign pop       = sq.pop_i && valid_out;
  // Input consumed straight through while empty: nothing is stored.
  assign bypass    = ft_active && pop;

  assign sq.ready_o = ready_q;
  assign sq.valid_o = valid_out;
  assign empty_o    = empty;
  assign usage_o    = usage_q;

  always_comb begin
    sq.lsu_ctrl_o = '0;
    if (!empty)                          sq.lsu_ctrl_o = mem_q[rptr_q];
    else if (FALL_THROUGH && sq.valid_i) sq.lsu_ctrl_o = sq.lsu_ctrl_i;
  end

  always_comb begin
    mem_d   = mem_q;
    vld_d   = vld_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    usage_d = usage_q;
    if (flush_i) begin
      vld_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      usage_d = '0;
    end else if (!bypass) begin
      if (push) begin
        mem_d[wptr_q] = sq.lsu_ctrl_i;
        vld_d[wptr_q] = 1'b1;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop) begin
        vld_d[rptr_q] = 1'b0;
        rptr_d        = rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   usage_d = usage_q + 1'b1;
        2'b01:   usage_d = usage_q - 1'b1;
        default: usage_d = usage_q;
      endcase
    end
    // Registered from the next count so pop_i never reaches ready_o combinationally.
    ready_d = (usage_d != cnt_t'(DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q   <= '{default: '0};
      vld_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
      ready_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      vld_q   <= vld_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      usage_q <= usage_d;
      ready_q <= ready_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign entry_hit[i] = vld_q[i] &&
      offset_hit(mem_q[i].vaddr[OFFSET_MSB:OFFSET_LSB], page_offset_i[OFFSET_MSB:OFFSET_LSB]);
  end

  assign page_offset_matches_o = !flush_i && ((|entry_hit) || (ft_active &&
    offset_hit(sq.lsu_ctrl_i.vaddr[OFFSET_MSB:OFFSET_LSB], page_offset_i[OFFSET_MSB:OFFSET_LSB])));

  assign unused_offset_bits = ^page_offset_i[OFFSET_LSB-1:0];

  pop_needs_head_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (sq.pop_i && !flush_i) |-> valid_out);

endmodule

// File: tb/tb_st_issue_queue.sv
// Directed bench for st_issue_queue: queue-level reference model checked every
// cycle plus hand-computed expectations at key points of each scenario.
module tb_st_issue_queue;
  import ariane_pkg::*;

  localparam int DEPTH = ST_ISSUE_QUEUE_DEPTH;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   flush = 1'b0;
  logic [11:0]            poff = '0;
  logic                   empty;
  logic [$clog2(DEPTH):0] usage;
  logic                   match;

  st_issue_queue_if sq_if ();

  st_issue_queue #(.DEPTH(DEPTH), .FALL_THROUGH(1'b1)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .flush_i               (flush),
    .sq                    (sq_if),
    .empty_o               (empty),
    .usage_o               (usage),
    .page_offset_i         (poff),
    .page_offset_matches_o (match)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  lsu_ctrl_t   mq[$];
  int unsigned dut_log[$];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lsu_ctrl_t mk(input int id, input logic [63:0] va);
    lsu_ctrl_t s = '0;
    s.vaddr     = va;
    s.data      = 64'hD0D0_0000_0000_0000 | 64'(id);
    s.be        = 8'h0F;
    s.operation = SD;
    s.trans_id  = TRANS_ID_BITS'(id);
    return s;
  endfunction

  // Queue-level model: outputs follow from the stored list and the inputs.
  task automatic model_cycle();
    bit ft, vexp, mexp, push, pop;
    if (rst) begin
      mq.delete();
      return;
    end
    ft   = (mq.size() == 0) && sq_if.valid_i && !flush;
    vexp = !flush && (mq.size() != 0 || ft);
    mexp = 1'b0;
    if (!flush) begin
      foreach (mq[i]) if (mq[i].vaddr[11:3] == poff[11:3]) mexp = 1'b1;
      if (ft && sq_if.lsu_ctrl_i.vaddr[11:3] == poff[11:3]) mexp = 1'b1;
    end
    chk("m_ready", sq_if.ready_o, mq.size() < DEPTH);
    chk("m_valid", sq_if.valid_o, vexp);
    chk("m_empty", empty, mq.size() == 0);
    chk("m_usage", usage, mq.size());
    chk("m_match", match, mexp);
    if (vexp) chk("m_head", sq_if.lsu_ctrl_o, (mq.size() != 0) ? mq[0] : sq_if.lsu_ctrl_i);
    if (sq_if.valid_o && sq_if.pop_i) dut_log.push_back(sq_if.lsu_ctrl_o.trans_id);
    if (flush) mq.delete();
    else begin
      push = sq_if.valid_i && (mq.size() < DEPTH);
      pop  = sq_if.pop_i && vexp;
      if (!(pop && mq.size() == 0)) begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(sq_if.lsu_ctrl_i);
      end
    end
  endtask

  always @(negedge clk) model_cycle();

  task automatic cyc(input bit v, input int id, input logic [63:0] va, input bit p, input bit f = 1'b0);
    @(posedge clk);
    #1;
    sq_if.valid_i    = v;
    sq_if.lsu_ctrl_i = v ? mk(id, va) : '0;
    sq_if.pop_i      = p;
    flush            = f;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_usage"}, usage, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_ready"}, sq_if.ready_o, 1);
    chk({tag, "_valid"}, sq_if.valid_o, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_ctrl"},  sq_if.lsu_ctrl_o, 0);
  endtask

  task automatic check_log(input string tag, input int unsigned exp[$]);
    chk({tag, "_len"}, dut_log.size(), exp.size());
    foreach (exp[i]) if (i < dut_log.size()) chk({tag, "_id"}, dut_log[i], exp[i]);
  endtask

  initial begin
    sq_if.valid_i    = 1'b0;
    sq_if.lsu_ctrl_i = '0;
    sq_if.pop_i      = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Fall-through push, then stored.
    cyc(1, 3, 64'h100, 0);
    #1 chk("t1_ft_valid", sq_if.valid_o, 1);
    chk("t1_ft_id", sq_if.lsu_ctrl_o.trans_id, 3);
    chk("t1_usage0", usage, 0);
    cyc(0, 0, 0, 0);
    #1 chk("t1_usage1", usage, 1);
    chk("t1_empty", empty, 0);
    chk("t1_head", sq_if.lsu_ctrl_o.trans_id, 3);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    #1 chk("t1_drained", usage, 0);

    // Fill, hold id 5 while full, pop frees a slot.
    dut_log.delete();
    cyc(1, 1, 64'h200, 0);
    cyc(1, 2, 64'h208, 0);
    cyc(1, 5, 64'h210, 0);
    #1 chk("t2_full_ready", sq_if.ready_o, 0);
    chk("t2_head1", sq_if.lsu_ctrl_o.trans_id, 1);
    cyc(1, 5, 64'h210, 1);
    #1 chk("t2_pop_ready", sq_if.ready_o, 0);
    cyc(1, 5, 64'h210, 0);
    #1 chk("t2_ready_back", sq_if.ready_o, 1);
    chk("t2_head2", sq_if.lsu_ctrl_o.trans_id, 2);
    chk("t2_usage1", usage, 1);
    cyc(0, 0, 0, 0);
    #1 chk("t2_id5_taken", usage, 2);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    #1 chk("t2_head5", sq_if.lsu_ctrl_o.trans_id, 5);
    cyc(0, 0, 0, 0);
    #1 check_log("t2_order", '{1, 2, 5});

    // Push+pop every cycle while empty: pure bypass.
    dut_log.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(1, i, 64'h300, 1);
      #1 chk("t3a_usage", usage, 0);
    end
    cyc(0, 0, 0, 0);
    #1 check_log("t3a_order", '{0, 1, 2, 3, 4, 5, 6, 7});

    // Push+pop every cycle with one entry resident: pointers walk and wrap.
    dut_log.delete();
    cyc(1, 0, 64'h400, 0);
    for (int i = 1; i < 8; i++) begin
      cyc(1, i, 64'h400, 1);
      #1 chk("t3b_usage", usage, 1);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    #1 chk("t3b_usage_end", usage, 0);
    check_log("t3b_order", '{0, 1, 2, 3, 4, 5, 6, 7});

    // Flush with a concurrent push and pop.
    poff = 12'h23C;
    cyc(1, 6, 64'h1238, 0);
    cyc(1, 7, 64'h1238, 0);
    cyc(1, 4, 64'h1238, 1, 1);
    #1 chk("t4_flush_valid", sq_if.valid_o, 0);
    chk("t4_flush_match", match, 0);
    cyc(0, 0, 0, 0);
    #1 chk("t4_usage", usage, 0);
    chk("t4_empty", empty, 1);
    chk("t4_ready", sq_if.ready_o, 1);
    chk("t4_valid", sq_if.valid_o, 0);

    // Page-offset aliasing.
    cyc(1, 1, 64'h1238, 0);
    #1 chk("t5_ft_match", match, 1);
    cyc(1, 2, 64'h2000, 0);
    #1 chk("t5_stored_match", match, 1);
    cyc(0, 0, 0, 0);
    poff = 12'h240;
    #1 chk("t5_other_dword", match, 0);
    poff = 12'h23C;
    #1 chk("t5_same_dword", match, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    #1 chk("t5_after_pop", match, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Asynchronous reset with two entries stored.
    cyc(1, 3, 64'h1238, 0);
    cyc(1, 4, 64'h1238, 0);
    cyc(0, 0, 0, 0);
    #1 chk("t6_usage2", usage, 2);
    chk("t6_match_pre", match, 1);
    #1 rst = 1'b1;
    #1 check_reset("t6_async");
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 2, 64'h500, 0);
    cyc(0, 0, 0, 0);
    #1 chk("t6_push_usage", usage, 1);
    chk("t6_push_id", sq_if.lsu_ctrl_o.trans_id, 2);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/st_issue_queue.md
Name: st_issue_queue

Overview:
- Small fall-through FIFO sitting directly upstream of the store unit inside the LSU.
- Accepts store/AMO requests (lsu_ctrl_t) from the LSU issue logic and presents the head entry to the store unit as valid_o / lsu_ctrl_o.
- The store unit consumes the head by asserting pop_i, and may stall for several cycles (TLB miss, full store buffer) without back-pressuring issue until the queue fills.
- Also reports whether any queued, not-yet-translated store aliases a given page offset, so the load path can hold off.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- FALL_THROUGH, 1, 1: input visible on lsu_ctrl_o in the same cycle when the queue is empty; 0: one-cycle registered latency.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- flush_i  input  1  drop all entries (pipeline flush).
- valid_i  input  1  new store/AMO request offered.
- lsu_ctrl_i  input  lsu_ctrl_t  request payload.
- ready_o  output  1  queue can accept; registered, equals !full.
- valid_o  output  1  head entry valid towards the store unit.
- lsu_ctrl_o  output  lsu_ctrl_t  head entry payload.
- pop_i  input  1  store unit consumed head this cycle.
- empty_o  output  1  no valid entry stored.
- usage_o  output  $clog2(DEPTH)+1  number of stored entries.
- page_offset_i  input  12  load page offset to check.
- page_offset_matches_o  output  1  a queued entry's vaddr[11:3] equals page_offset_i[11:3].

Behaviour:
- Reset values: all entries invalid, pointers 0, usage_o=0, empty_o=1, ready_o=1, valid_o=0, page_offset_matches_o=0, lsu_ctrl_o payload all zeros.
- Push: occurs when valid_i && ready_o, unless flush_i is high.
  - valid_i while ready_o=0 is ignored; issue must hold the request.
- Pop: occurs when pop_i && valid_o.
  - pop_i with valid_o=0 is ignored and flagged by an assertion.
- Fall-through (FALL_THROUGH=1) with the queue empty and valid_i:
  - valid_o=1, lsu_ctrl_o=lsu_ctrl_i combinationally.
  - If pop_i is also high that cycle, nothing is written and usage stays 0.
  - Otherwise the entry is written.
- Registered mode (FALL_THROUGH=0): valid_o = !empty; a pushed entry is visible the next cycle.
- Simultaneous push and pop when not empty: usage unchanged; write at write pointer, advance both pointers.
- Full: ready_o=0 next cycle.
  - ready_o does not depend on pop_i, so there is no combinational path from pop_i to ready_o.
  - A push in the same cycle as a pop when full is therefore impossible.
  - Throughput at full is one entry per two cycles; accepted.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. usage_o is tracked separately; full = (usage == DEPTH).
- flush_i:
  - Next cycle: usage=0, pointers=0, all entries invalid.
  - Same cycle: a concurrent push is discarded, valid_o is forced to 0, and pop_i is ignored.
- page_offset_matches_o:
  - Combinational OR over stored valid entries of (entry.vaddr[11:3] == page_offset_i[11:3]).
  - Also includes the fall-through input when it is being presented.
  - Forced to 0 during flush_i.
- Reset asserted mid-operation: immediate return to reset values, independent of clock.
- No data is modified. Entry payloads are stored verbatim (data, be, operator, trans_id, vaddr).

Decomposition:
- lsu_ctrl_t and TRANS_ID_BITS come from ariane_pkg.
- Add a shared constant ST_ISSUE_QUEUE_DEPTH = 2 to ariane_pkg.
- No sub-module. Storage is a register array of lsu_ctrl_t plus a per-entry valid bit. The offset comparator is a generate loop inside the block.

Test Plan:
- Reset, then push trans_id=3 with pop_i=0 → same cycle (FALL_THROUGH=1) valid_o=1, lsu_ctrl_o.trans_id=3; next cycle usage_o=1, empty_o=0.
- Push ids 1 and 2 with no pop → ready_o=0 after the second; valid_i with id=5 held high is not accepted; pop → next cycle ready_o=1, head id=2, and id=5 is accepted.
- Push and pop every cycle for 8 cycles, ids 0..7 → output order 0..7, usage_o never exceeds 1, pointers wrap correctly.
- Queue holds 2 entries and flush_i is asserted with valid_i=1, pop_i=1 → valid_o=0 that cycle; next cycle usage_o=0, empty_o=1, ready_o=1.
- Entry with vaddr=0x1238 queued; page_offset_i=0x23C → matches=1; page_offset_i=0x240 → matches=0; after the entry is popped, 0x23C → matches=0.
- rst_i asserted mid-cycle with 2 entries stored → outputs return to reset values immediately without a clock edge; first push after release is accepted.
